// File: rtl/posit_op_bridge.sv
// rtl/posit_op_bridge.sv - tag-sequenced command bridge from host PIO registers to a valid/ready posit core
module posit_op_bridge #(
    parameter int NBITS          = 32,
    parameter int OP_W           = 2,
    parameter int TAG_W          = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NBITS-1:0] host_num1,
    input  logic [NBITS-1:0] host_num2,
    input  logic [OP_W-1:0]  host_op,
    input  logic [TAG_W-1:0] host_tag,
    output logic [NBITS-1:0] host_result,
    output logic [31:0]      host_status,
    output logic             core_in_valid,
    input  logic             core_in_ready,
    output logic [NBITS-1:0] core_num1,
    output logic [NBITS-1:0] core_num2,
    output logic [OP_W-1:0]  core_op,
    input  logic             core_out_valid,
    input  logic [NBITS-1:0] core_result
);

    localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [NBITS-1:0] NAR      = {1'b1, {(NBITS-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t             state, state_nxt;
    logic [TAG_W-1:0]   last_tag;
    logic [TAG_W-1:0]   cmd_tag;
    logic [TMR_W-1:0]   timer;
    logic               busy, done, timed_out;
    logic [7:0]         tag_echo;
    logic [15:0]        count;

    logic launch, accept, complete, expire;

    assign launch   = (state == IDLE) && (host_tag != last_tag);
    assign accept   = (state == ISSUE) && core_in_valid && core_in_ready;
    assign complete = (state == WAIT) && core_out_valid;
    // A completion landing on the terminal timer cycle takes precedence over the abort.
    assign expire   = (state != IDLE) && (timer == TMR_LAST) && !complete;

    assign host_status = {count, tag_echo, 5'd0, timed_out, done, busy};

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (launch) state_nxt = ISSUE;
            ISSUE:   if (expire) state_nxt = IDLE;
                     else if (accept) state_nxt = WAIT;
            WAIT:    if (complete || expire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_tag      <= '0;
            cmd_tag       <= '0;
            timer         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            timed_out     <= 1'b0;
            tag_echo      <= '0;
            count         <= '0;
            host_result   <= '0;
            core_in_valid <= 1'b0;
            core_num1     <= '0;
            core_num2     <= '0;
            core_op       <= '0;
        end else begin
            if (launch) begin
                core_num1     <= host_num1;
                core_num2     <= host_num2;
                core_op       <= host_op;
                core_in_valid <= 1'b1;
                last_tag      <= host_tag;
                cmd_tag       <= host_tag;
                done          <= 1'b0;
                timed_out     <= 1'b0;
                busy          <= 1'b1;
                timer         <= '0;
            end else if (state != IDLE) begin
                timer <= timer + TMR_W'(1);
            end

            if (accept) core_in_valid <= 1'b0;

            if (complete) begin
                host_result <= core_result;
                done        <= 1'b1;
                busy        <= 1'b0;
                tag_echo    <= 8'(cmd_tag);
                if (count != 16'hFFFF) count <= count + 16'd1;
            end else if (expire) begin
                host_result   <= NAR;
                timed_out     <= 1'b1;
                busy          <= 1'b0;
                tag_echo      <= 8'(cmd_tag);
                core_in_valid <= 1'b0;
            end
        end
    end

endmodule
